dm_store_buffer: RTL and testbench
==================================

Name: dm_store_buffer

Overview:
- Store buffer directly upstream of the data memory.
- Accepts word stores from the datapath's memory stage and queues them in a small FIFO.
- Drains the oldest queued store to the DM write port, at most one per cycle.
- Forwards the youngest matching buffered data to loads, so loads never see stale DM contents.

Parameters:
DEPTH, 4, number of buffered stores; power of two, >= 2
AW, 10, word-address width; matches the DM word index
DW, 32, data width

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  asynchronous, active-low reset; clears the buffer
st_valid  input  1  store request this cycle
st_addr  input  AW  store word address
st_data  input  DW  store data
st_pc4  input  32  PC+4 of the storing instruction, carried to the DM for its write log
st_ready  output  1  buffer can accept a store this cycle
drain_en  input  1  DM write port is available this cycle
dm_we  output  1  write enable to the DM
dm_addr  output  AW  head-entry address
dm_data  output  DW  head-entry data
dm_pc4  output  32  head-entry PC+4
ld_addr  input  AW  load word address, for forwarding lookup
fwd_hit  output  1  a buffered entry matches ld_addr
fwd_data  output  DW  data of the youngest matching entry
count  output  log2(DEPTH)+1  number of valid entries
empty  output  1  count == 0

Behaviour:
- Storage:
  - Circular FIFO of DEPTH entries {addr, data, pc4}.
  - Head pointer (rd_ptr), tail pointer (wr_ptr), each log2(DEPTH) bits, wrapping modulo DEPTH.
  - Separate count register.
- Reset (reset low, asynchronous):
  - rd_ptr = wr_ptr = 0, count = 0, all entry valid flags cleared.
  - Outputs: empty = 1, st_ready = 1, dm_we = 0, fwd_hit = 0, fwd_data = 0, dm_addr / dm_data / dm_pc4 = 0.
  - Stores pending at reset are discarded and never reach the DM.
  - Entry payload contents need not be cleared.
- st_ready = (count != DEPTH). Purely combinational; does not depend on st_valid or drain_en.
- Push: occurs at a rising edge when st_valid && st_ready.
  - Entry written at wr_ptr; wr_ptr increments.
  - st_valid while not ready is ignored; the upstream stage must stall and hold the request.
- Drain outputs:
  - dm_we = drain_en && !empty (combinational).
  - dm_addr / dm_data / dm_pc4 = head entry while !empty; 0 when empty.
- Pop: occurs at the rising edge where dm_we = 1.
  - The DM captures the head at the same edge.
  - rd_ptr increments and the entry's valid flag clears.
  - Latency: a store pushed into an empty buffer at edge N appears on dm_* during cycle N+1 and is written at edge N+1 if drain_en = 1.
- Simultaneous push and pop:
  - Both take effect; count unchanged.
  - When full, st_ready = 0 regardless of the pop; no same-cycle refill of a full buffer.
- Count update: count' = count + push − pop. Never exceeds DEPTH, never underflows.
- Forwarding (combinational):
  - Compares ld_addr against every valid entry, including the head entry being drained this cycle.
  - fwd_hit = 1 if any entry matches.
  - fwd_data = data of the youngest match, by age from rd_ptr; 0 when no hit.
  - A store presented on st_* in the same cycle is not visible to forwarding; the datapath's own bypass covers that case.
- Ordering: stores reach the DM strictly in push order. Duplicate addresses are not coalesced.
- Pointer wrap: after DEPTH pushes, wr_ptr returns to 0. Age ordering for forwarding must remain correct across the wrap.
- No X propagation on outputs after reset, including for unwritten entries.

Test Plan:
1. Reset, then single store addr=0x005, data=0xDEADBEEF, drain_en=1 -> cycle after push: dm_we=1, dm_addr=0x005, dm_data=0xDEADBEEF; next cycle empty=1, dm_we=0.
2. drain_en=0, push 4 stores (addr 1..4, data 0x11..0x44) -> count=4, st_ready=0; 5th st_valid (addr 5) ignored; raise drain_en -> DM writes addr 1,2,3,4 in order over 4 cycles, addr 5 never written.
3. drain_en=0, push addr=0x010 data=0xA, then addr=0x010 data=0xB, set ld_addr=0x010 -> fwd_hit=1, fwd_data=0xB; ld_addr=0x011 -> fwd_hit=0, fwd_data=0.
4. Full buffer, drain_en=1 and st_valid=1 same cycle -> pop occurs, push rejected, count=3; next cycle st_ready=1 and push+pop together keep count=3.
5. Stream 10 stores (addr 0x100+i, data i) with drain_en toggling 1,0,1,0... -> all 10 written in order, pointers wrap twice, forwarding on ld_addr=0x109 returns 9 while that entry is pending.
6. Push 3 stores with drain_en=0, assert reset low mid-cycle -> outputs clear immediately without waiting for clk: count=0, empty=1, dm_we=0; after release, no stale write ever appears on dm_we.

Source files
------------

// File: rtl/dm_store_buffer.sv
// Store buffer sitting directly in front of the data memory.
// Word stores from the memory stage are queued in a small circular FIFO,
// the oldest entry is drained to the DM write port (at most one per cycle),
// and loads are forwarded the youngest matching buffered data so they never
// observe stale DM contents.
module dm_store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 10,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     st_valid,
    input  logic [AW-1:0]            st_addr,
    input  logic [DW-1:0]            st_data,
    input  logic [31:0]              st_pc4,
    output logic                     st_ready,
    input  logic                     drain_en,
    output logic                     dm_we,
    output logic [AW-1:0]            dm_addr,
    output logic [DW-1:0]            dm_data,
    output logic [31:0]              dm_pc4,
    input  logic [AW-1:0]            ld_addr,
    output logic                     fwd_hit,
    output logic [DW-1:0]            fwd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0]    addr_mem [DEPTH];
    logic [DW-1:0]    data_mem [DEPTH];
    logic [31:0]      pc4_mem  [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    fwd_idx;
    logic             push;
    logic             pop;

    // A full buffer refuses stores even when the head drains this cycle, so
    // the accept decision never depends on the DM port being free.
    assign empty    = (count == '0);
    assign st_ready = (count != (PW + 1)'(DEPTH));
    assign push     = st_valid && st_ready;
    assign dm_we    = drain_en && !empty;
    assign pop      = dm_we;

    // Head entry is presented to the DM only while it holds real data.
    assign dm_addr  = empty ? '0 : addr_mem[rd_ptr];
    assign dm_data  = empty ? '0 : data_mem[rd_ptr];
    assign dm_pc4   = empty ? '0 : pc4_mem[rd_ptr];

    // Pointer, valid-flag and occupancy bookkeeping; a reset discards every
    // pending store so none of them ever reaches the DM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            valid_q <= '0;
        end else begin
            if (push) begin
                wr_ptr          <= wr_ptr + 1'b1;
                valid_q[wr_ptr] <= 1'b1;
            end
            if (pop) begin
                rd_ptr          <= rd_ptr + 1'b1;
                valid_q[rd_ptr] <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage; cleared on reset so nothing undefined can leak out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem[i] <= '0;
                data_mem[i] <= '0;
                pc4_mem[i]  <= '0;
            end
        end else if (push) begin
            addr_mem[wr_ptr] <= st_addr;
            data_mem[wr_ptr] <= st_data;
            pc4_mem[wr_ptr]  <= st_pc4;
        end
    end

    // Walk entries oldest-to-youngest from the head so a later match
    // overrides an earlier one; this keeps age order correct across wrap.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = rd_ptr;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = rd_ptr + k[PW-1:0];
            if (valid_q[fwd_idx] && (addr_mem[fwd_idx] == ld_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_mem[fwd_idx];
            end
        end
    end

endmodule

// File: tb/tb_dm_store_buffer.sv
// Self-checking bench for dm_store_buffer: a queue-based reference model
// acts as the scoreboard for the DM write stream and forwarding, and a
// vector table carries hand-derived occupancy/forwarding expectations.
module tb_dm_store_buffer;

    logic        clk;
    logic        reset;
    logic        st_valid;
    logic [9:0]  st_addr;
    logic [31:0] st_data;
    logic [31:0] st_pc4;
    logic        st_ready;
    logic        drain_en;
    logic        dm_we;
    logic [9:0]  dm_addr;
    logic [31:0] dm_data;
    logic [31:0] dm_pc4;
    logic [9:0]  ld_addr;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic [2:0]  count;
    logic        empty;

    dm_store_buffer #(.DEPTH(4), .AW(10), .DW(32)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
        .st_pc4(st_pc4), .st_ready(st_ready),
        .drain_en(drain_en), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_data(dm_data), .dm_pc4(dm_pc4),
        .ld_addr(ld_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
        .count(count), .empty(empty)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [9:0]  a;
        logic [31:0] d;
        logic [31:0] pc4;
    } entry_t;

    typedef struct {
        logic        v;
        logic [9:0]  a;
        logic [31:0] d;
        logic        de;
        logic [9:0]  la;
        logic [2:0]  ecount;
        logic        ehit;
        logic [31:0] efwd;
    } vec_t;

    entry_t      sb[$];
    vec_t        vecs[24];
    int          tests;
    int          failed;
    int          pc_seq;
    int          write_count;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Compare DUT outputs against the queue model, then advance the model
    // to reflect what the coming rising edge will do.
    task automatic checkOutput();
        logic        exp_ready;
        logic        exp_pop;
        logic        exp_hit;
        logic [31:0] exp_fwd;
        entry_t      e;
        exp_ready = (sb.size() != 4);
        exp_pop   = drain_en && (sb.size() != 0);
        exp_hit   = 1'b0;
        exp_fwd   = '0;
        foreach (sb[i]) begin
            if (sb[i].a == ld_addr) begin
                exp_hit = 1'b1;
                exp_fwd = sb[i].d;
            end
        end
        checkVal("st_ready", {31'd0, st_ready}, {31'd0, exp_ready});
        checkVal("count", {29'd0, count}, sb.size());
        checkVal("empty", {31'd0, empty}, {31'd0, sb.size() == 0});
        checkVal("dm_we", {31'd0, dm_we}, {31'd0, exp_pop});
        checkVal("fwd_hit", {31'd0, fwd_hit}, {31'd0, exp_hit});
        checkVal("fwd_data", fwd_data, exp_fwd);
        if (sb.size() == 0) begin
            checkVal("dm_addr_idle", {22'd0, dm_addr}, 32'd0);
            checkVal("dm_data_idle", dm_data, 32'd0);
        end else if (exp_pop) begin
            e = sb.pop_front();
            checkVal("dm_addr", {22'd0, dm_addr}, {22'd0, e.a});
            checkVal("dm_data", dm_data, e.d);
            checkVal("dm_pc4", dm_pc4, e.pc4);
        end else begin
            checkVal("dm_addr_head", {22'd0, dm_addr}, {22'd0, sb[0].a});
        end
        if (dm_we === 1'b1) write_count++;
        if (st_valid && exp_ready) sb.push_back('{st_addr, st_data, st_pc4});
    endtask

    // Drive one cycle of stimulus on the falling edge and check mid-cycle
    task automatic applyStimulus(input logic v, input logic [9:0] a, input logic [31:0] d,
                                 input logic de, input logic [9:0] la);
        @(negedge clk);
        st_valid = v;
        st_addr  = a;
        st_data  = d;
        st_pc4   = 32'h0040_0000 + pc_seq * 4;
        drain_en = de;
        ld_addr  = la;
        pc_seq++;
        #1;
        checkOutput();
    endtask

    // Watchdog so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int i;
        int cyc;
        tests = 0; failed = 0; pc_seq = 0; write_count = 0;

        // occupancy/forwarding expectations are the count before the edge
        vecs[0]  = '{1'b1, 10'h001, 32'h11, 1'b0, 10'h002, 3'd0, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 10'h002, 32'h22, 1'b0, 10'h002, 3'd1, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 10'h003, 32'h33, 1'b0, 10'h002, 3'd2, 1'b1, 32'h22};
        vecs[3]  = '{1'b1, 10'h004, 32'h44, 1'b0, 10'h004, 3'd3, 1'b0, 32'h0};
        vecs[4]  = '{1'b1, 10'h005, 32'h55, 1'b0, 10'h004, 3'd4, 1'b1, 32'h44};
        vecs[5]  = '{1'b1, 10'h005, 32'h55, 1'b0, 10'h005, 3'd4, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, 10'h000, 32'h0,  1'b1, 10'h001, 3'd4, 1'b1, 32'h11};
        vecs[7]  = '{1'b0, 10'h000, 32'h0,  1'b1, 10'h001, 3'd3, 1'b0, 32'h0};
        vecs[8]  = '{1'b0, 10'h000, 32'h0,  1'b1, 10'h3FF, 3'd2, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 10'h000, 32'h0,  1'b1, 10'h004, 3'd1, 1'b1, 32'h44};
        vecs[10] = '{1'b0, 10'h000, 32'h0,  1'b1, 10'h004, 3'd0, 1'b0, 32'h0};
        vecs[11] = '{1'b1, 10'h010, 32'hA,  1'b0, 10'h010, 3'd0, 1'b0, 32'h0};
        vecs[12] = '{1'b1, 10'h010, 32'hB,  1'b0, 10'h010, 3'd1, 1'b1, 32'hA};
        vecs[13] = '{1'b0, 10'h000, 32'h0,  1'b0, 10'h010, 3'd2, 1'b1, 32'hB};
        vecs[14] = '{1'b0, 10'h000, 32'h0,  1'b0, 10'h011, 3'd2, 1'b0, 32'h0};
        vecs[15] = '{1'b1, 10'h020, 32'h20, 1'b0, 10'h010, 3'd2, 1'b1, 32'hB};
        vecs[16] = '{1'b1, 10'h021, 32'h21, 1'b0, 10'h021, 3'd3, 1'b0, 32'h0};
        vecs[17] = '{1'b1, 10'h022, 32'h22, 1'b1, 10'h021, 3'd4, 1'b1, 32'h21};
        vecs[18] = '{1'b1, 10'h022, 32'h22, 1'b1, 10'h010, 3'd3, 1'b1, 32'hB};
        vecs[19] = '{1'b0, 10'h000, 32'h0,  1'b0, 10'h022, 3'd3, 1'b1, 32'h22};
        vecs[20] = '{1'b0, 10'h000, 32'h0,  1'b1, 10'h020, 3'd3, 1'b1, 32'h20};
        vecs[21] = '{1'b0, 10'h000, 32'h0,  1'b1, 10'h020, 3'd2, 1'b0, 32'h0};
        vecs[22] = '{1'b0, 10'h000, 32'h0,  1'b1, 10'h022, 3'd1, 1'b1, 32'h22};
        vecs[23] = '{1'b0, 10'h000, 32'h0,  1'b1, 10'h022, 3'd0, 1'b0, 32'h0};

        // Reset state, with drain requested to prove nothing is written
        reset = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_pc4 = '0;
        drain_en = 1'b1; ld_addr = '0;
        #3;
        checkVal("rst_empty", {31'd0, empty}, 32'd1);
        checkVal("rst_st_ready", {31'd0, st_ready}, 32'd1);
        checkVal("rst_dm_we", {31'd0, dm_we}, 32'd0);
        checkVal("rst_count", {29'd0, count}, 32'd0);
        checkVal("rst_fwd_hit", {31'd0, fwd_hit}, 32'd0);
        checkVal("rst_fwd_data", fwd_data, 32'd0);
        checkVal("rst_dm_addr", {22'd0, dm_addr}, 32'd0);
        checkVal("rst_dm_data", dm_data, 32'd0);
        checkVal("rst_dm_pc4", dm_pc4, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Single store written the cycle after it is pushed
        applyStimulus(1'b1, 10'h005, 32'hDEADBEEF, 1'b1, 10'h000);
        applyStimulus(1'b0, 10'h000, 32'h0, 1'b1, 10'h000);
        checkVal("t1_dm_we", {31'd0, dm_we}, 32'd1);
        checkVal("t1_dm_addr", {22'd0, dm_addr}, 32'h005);
        applyStimulus(1'b0, 10'h000, 32'h0, 1'b1, 10'h000);
        checkVal("t1_empty", {31'd0, empty}, 32'd1);

        // Fill/overflow, ordered drain, duplicate-address forwarding, full push+pop
        for (int k = 0; k < 24; k++) begin
            applyStimulus(vecs[k].v, vecs[k].a, vecs[k].d, vecs[k].de, vecs[k].la);
            checkVal($sformatf("vec%0d_count", k), {29'd0, count}, {29'd0, vecs[k].ecount});
            checkVal($sformatf("vec%0d_hit", k), {31'd0, fwd_hit}, {31'd0, vecs[k].ehit});
            checkVal($sformatf("vec%0d_fwd", k), fwd_data, vecs[k].efwd);
        end

        // Stream 10 stores with alternating drain; stalled requests are held
        write_count = 0;
        i = 0;
        cyc = 0;
        while (i < 10 && cyc < 100) begin
            logic accept;
            accept = (sb.size() != 4);
            applyStimulus(1'b1, 10'h100 + 10'(i), 32'(i), (cyc % 2) == 0, 10'h109);
            if (accept) i++;
            cyc++;
        end
        repeat (8) applyStimulus(1'b0, 10'h000, 32'h0, 1'b1, 10'h109);
        checkVal("t5_write_count", write_count, 32'd10);
        checkVal("t5_empty", {31'd0, empty}, 32'd1);

        // Asynchronous reset mid-cycle discards pending stores
        applyStimulus(1'b1, 10'h031, 32'h31, 1'b0, 10'h031);
        applyStimulus(1'b1, 10'h032, 32'h32, 1'b0, 10'h031);
        applyStimulus(1'b1, 10'h033, 32'h33, 1'b0, 10'h031);
        @(posedge clk);
        #2;
        st_valid = 1'b0;
        drain_en = 1'b1;
        reset = 1'b0;
        #1;
        checkVal("t6_count", {29'd0, count}, 32'd0);
        checkVal("t6_empty", {31'd0, empty}, 32'd1);
        checkVal("t6_dm_we", {31'd0, dm_we}, 32'd0);
        checkVal("t6_fwd_hit", {31'd0, fwd_hit}, 32'd0);
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        repeat (4) applyStimulus(1'b0, 10'h000, 32'h0, 1'b1, 10'h032);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
